adc_fifo_reader: RTL and testbench

- Drain side of the ADC sample FIFO.
- Pops 8-bit samples that adc_control pushed with fifo_nextin, and serializes them bit-by-bit for the reply path.
- Appends an 8-bit additive checksum after the last sample.
- Sits between the sample FIFO read port and the tx bit encoder, paced by the encoder's bit request.

---
 rtl/adc_fifo_reader_if.sv | 11 +
 rtl/adc_fifo_reader.sv | 90 +++++++++
 tb/tb_adc_fifo_reader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_fifo_reader_if.sv
// adc_fifo_reader_if: sample FIFO read port plus serial bit handshake toward the tx encoder
interface adc_fifo_reader_if;
  logic       fifo_empty;
  logic [7:0] fifo_dataout;
  logic       fifo_nextout;
  logic       bit_req;
  logic       tx_bit;
  logic       tx_valid;
  modport master (input fifo_empty, fifo_dataout, bit_req, output fifo_nextout, tx_bit, tx_valid);
  modport slave (output fifo_empty, fifo_dataout, bit_req, input fifo_nextout, tx_bit, tx_valid);
endinterface

// File: rtl/adc_fifo_reader.sv
// adc_fifo_reader: pops ADC samples, serializes them per encoder bit request, then a mod-256 checksum
module adc_fifo_reader #(
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] PAD_BYTE  = 8'h00,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        sample_count,
  input  logic              abort,
  adc_fifo_reader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              underrun
);
  typedef enum logic [2:0] {IDLE, WAIT, POP, LOAD, SHIFT, CSUM, DONE} state_t;
  state_t state, state_d;
  logic [7:0] n, csum, sr, wait_cnt, n_dec, sr_shift;
  logic [2:0] bit_cnt;
  logic valid, consume, last, timeout;
  assign n_dec    = n - 8'(n != 8'd0);
  assign sr_shift = MSB_FIRST ? {sr[6:0], 1'b0} : {1'b0, sr[7:1]};
  assign timeout  = wait_cnt == 8'(TIMEOUT - 1);
  always_comb begin
    valid            = state == SHIFT || state == CSUM;
    consume          = valid & bus.bit_req;
    last             = consume && bit_cnt == 3'd7;
    bus.tx_valid     = valid;
    bus.tx_bit       = valid & (MSB_FIRST ? sr[7] : sr[0]);
    bus.fifo_nextout = state == POP;
    busy             = state != IDLE && state != DONE;
    done             = state == DONE;
    state_d          = state;
    case (state)
      IDLE:    state_d = start ? (sample_count != 8'd0 ? WAIT : CSUM) : IDLE;
      WAIT:    state_d = !bus.fifo_empty ? POP : timeout ? SHIFT : WAIT;
      POP:     state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = last ? (n != 8'd0 ? WAIT : CSUM) : SHIFT;
      CSUM:    state_d = last ? DONE : CSUM;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n        <= '0;
      csum     <= '0;
      sr       <= '0;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      underrun <= 1'b0;
    end else if (!abort) begin
      case (state)
        IDLE: if (start) begin
          n        <= sample_count;
          csum     <= '0;
          sr       <= '0;
          wait_cnt <= '0;
          bit_cnt  <= '0;
          underrun <= 1'b0;
        end
        WAIT: if (bus.fifo_empty) begin
          if (timeout) begin
            sr       <= PAD_BYTE;
            csum     <= csum + PAD_BYTE;
            n        <= n_dec;
            underrun <= 1'b1;
          end else wait_cnt <= wait_cnt + 8'd1;
        end
        LOAD: begin
          sr   <= bus.fifo_dataout;
          csum <= csum + bus.fifo_dataout;
          n    <= n_dec;
        end
        // the last data bit hands the checksum straight to the shifter; a WAIT detour reloads it anyway
        SHIFT, CSUM: if (consume) begin
          bit_cnt  <= bit_cnt + 3'd1;
          sr       <= (last && state == SHIFT) ? csum : sr_shift;
          wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_fifo_reader.sv
// tb_adc_fifo_reader: two readers (MSB-first and LSB-first) against a byte-stream model plus literal checks
module tb_adc_fifo_reader;
  logic clk = 0, reset = 1, start = 0, abort = 0, bit_req = 0;
  logic [7:0] sample_count = 0;
  int total = 0, bad = 0;
  int lat, v, gp;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit MSB = (g == 0);
    adc_fifo_reader_if bus();
    logic busy, done, underrun;
    logic [7:0] fq[$];
    logic [7:0] dout = 8'h00;
    logic exp_q[$];
    logic [31:0] got = '1;
    logic [7:0] cs, b;
    int pops = 0, exp_pops = 0;
    bit active = 0, done_due = 0, und_exp = 0, idle0;
    assign bus.fifo_empty   = fq.size() == 0;
    assign bus.fifo_dataout = dout;
    assign bus.bit_req      = bit_req;
    adc_fifo_reader #(.TIMEOUT(4), .PAD_BYTE(8'h00), .MSB_FIRST(MSB)) dut (
      .clk(clk), .reset(reset), .start(start), .sample_count(sample_count), .abort(abort),
      .bus(bus), .busy(busy), .done(done), .underrun(underrun));
    // model: a readout is the list of FIFO bytes (or pad) plus their sum, sent in order
    always @(negedge clk) begin
      if (!reset) begin
        chk($sformatf("g%0d reset_outputs", g),
            {bus.fifo_nextout, bus.tx_valid, bus.tx_bit, busy, done, underrun}, 0);
        active = 0; done_due = 0; und_exp = 0; exp_q.delete();
      end else begin
        idle0 = !active;
        if (done_due) begin
          chk($sformatf("g%0d done", g), done, 1);
          chk($sformatf("g%0d busy_in_done", g), busy, 0);
          chk($sformatf("g%0d pop_count", g), pops, exp_pops);
          chk($sformatf("g%0d underrun_end", g), underrun, und_exp);
          active = 0; done_due = 0;
        end else begin
          chk($sformatf("g%0d done_low", g), done, 0);
          chk($sformatf("g%0d busy", g), busy, active);
          if (!active) chk($sformatf("g%0d underrun_idle", g), underrun, und_exp);
        end
        chk($sformatf("g%0d pop_while_idle", g), bus.fifo_nextout & !active, 0);
        if (bus.tx_valid) begin
          chk($sformatf("g%0d tx_valid_expected", g), bus.tx_valid, active && exp_q.size() != 0);
          if (exp_q.size() != 0) begin
            chk($sformatf("g%0d tx_bit", g), bus.tx_bit, exp_q[0]);
            if (bit_req) begin
              got = {got[30:0], bus.tx_bit};
              void'(exp_q.pop_front());
              done_due = exp_q.size() == 0;
            end
          end
        end
        if (abort) begin
          active = 0; done_due = 0; exp_q.delete();
        end else if (start && idle0) begin
          got = '1; pops = 0; exp_pops = 0; und_exp = 0; cs = 0;
          for (int i = 0; i < int'(sample_count); i++) begin
            b = (i < fq.size()) ? fq[i] : 8'h00;
            if (i < fq.size()) exp_pops++; else und_exp = 1;
            cs += b;
            for (int k = 0; k < 8; k++) exp_q.push_back(MSB ? b[7-k] : b[k]);
          end
          for (int k = 0; k < 8; k++) exp_q.push_back(MSB ? cs[7-k] : cs[k]);
          active = 1;
        end
        if (bus.fifo_nextout && fq.size() != 0) begin
          dout = fq.pop_front();
          pops++;
        end
      end
    end
  end

  task automatic go(input logic [7:0] n);
    @(posedge clk); #1;
    sample_count = n; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    while (cnt < max) begin
      @(negedge clk); cnt++;
      if (g_dut[0].bus.tx_valid) return;
    end
    chk("wait_valid_timeout", g_dut[0].bus.tx_valid, 1);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (g_dut[0].done) return;
    end
    chk("wait_done_timeout", g_dut[0].done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #2 reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    // two samples, encoder always requesting
    g_dut[0].fq = {8'hA5, 8'h3C};
    g_dut[1].fq = {8'hA5, 8'h3C};
    bit_req = 1;
    go(2);
    wait_valid(20, lat);
    chk("t1 start_latency", lat, 4);
    v = 0;
    while (g_dut[0].bus.tx_valid && v < 20) begin @(negedge clk); v++; end
    chk("t1 bits_per_byte", v, 8);
    gp = 0;
    while (!g_dut[0].bus.tx_valid && gp < 20) begin gp++; @(negedge clk); end
    chk("t1 byte_gap", gp, 3);
    wait_done(100);
    chk("t1 msb_stream", g_dut[0].got, 32'hFFA53CE1);
    chk("t1 lsb_stream", g_dut[1].got, 32'hFFA53C87);
    chk("t1 pops", g_dut[0].pops, 2);
    chk("t1 underrun", g_dut[0].underrun, 0);
    @(negedge clk);
    chk("t1 busy_after", g_dut[0].busy, 0);
    // checksum only
    go(0);
    wait_valid(20, lat);
    chk("t2 start_latency", lat, 1);
    wait_done(50);
    chk("t2 stream", g_dut[0].got, 32'hFFFFFF00);
    chk("t2 pops", g_dut[0].pops, 0);
    @(negedge clk);
    chk("t2 busy_after_done", g_dut[0].busy, 0);
    // empty FIFO: pad after timeout
    go(1);
    wait_valid(20, lat);
    chk("t3 timeout_latency", lat, 5);
    wait_done(50);
    chk("t3 stream", g_dut[0].got, 32'hFFFF0000);
    chk("t3 underrun0", g_dut[0].underrun, 1);
    chk("t3 underrun1", g_dut[1].underrun, 1);
    chk("t3 pops", g_dut[0].pops, 0);
    repeat (2) @(negedge clk);
    chk("t3 underrun_sticky", g_dut[0].underrun, 1);
    // bit order
    g_dut[0].fq = {8'h01};
    g_dut[1].fq = {8'h01};
    go(1);
    wait_done(60);
    chk("t4 msb_stream", g_dut[0].got, 32'hFFFF0101);
    chk("t4 lsb_stream", g_dut[1].got, 32'hFFFF8080);
    chk("t4 underrun_cleared", g_dut[1].underrun, 0);
    // abort after third bit of first of three bytes
    g_dut[0].fq = {8'h11, 8'h22, 8'h33};
    g_dut[1].fq = {8'h11, 8'h22, 8'h33};
    bit_req = 0;
    go(3);
    wait_valid(20, lat);
    @(posedge clk); #1 bit_req = 1;
    repeat (3) @(posedge clk);
    #1 bit_req = 0; abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("t5 busy0", g_dut[0].busy, 0);
    chk("t5 busy1", g_dut[1].busy, 0);
    chk("t5 tx_valid", g_dut[0].bus.tx_valid, 0);
    chk("t5 msb_bits", g_dut[0].got, 32'hFFFFFFF8);
    chk("t5 lsb_bits", g_dut[1].got, 32'hFFFFFFFC);
    repeat (5) @(negedge clk);
    chk("t5 fifo_left0", g_dut[0].fq.size(), 2);
    chk("t5 fifo_left1", g_dut[1].fq.size(), 2);
    bit_req = 1;
    go(2);
    wait_done(80);
    chk("t5 resume_msb", g_dut[0].got, 32'hFF223355);
    chk("t5 resume_lsb", g_dut[1].got, 32'hFF44CCAA);
    // reset during LOAD, idle bit requests, start while busy
    g_dut[0].fq = {8'h77};
    g_dut[1].fq = {8'h77};
    go(1);
    @(posedge clk);
    @(posedge clk); #1 reset = 0;
    #1;
    chk("t6 reset_out0", {g_dut[0].bus.fifo_nextout, g_dut[0].bus.tx_valid, g_dut[0].bus.tx_bit,
                          g_dut[0].busy, g_dut[0].done, g_dut[0].underrun}, 0);
    chk("t6 reset_out1", {g_dut[1].bus.fifo_nextout, g_dut[1].bus.tx_valid, g_dut[1].bus.tx_bit,
                          g_dut[1].busy, g_dut[1].done, g_dut[1].underrun}, 0);
    chk("t6 popped_before_reset", g_dut[0].fq.size(), 0);
    @(posedge clk); #1 reset = 1;
    repeat (3) @(posedge clk);
    g_dut[0].fq = {8'h4B};
    g_dut[1].fq = {8'h4B};
    go(1);
    @(posedge clk); #1 sample_count = 3; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(60);
    chk("t6 msb_stream", g_dut[0].got, 32'hFFFF4B4B);
    chk("t6 lsb_stream", g_dut[1].got, 32'hFFFFD2D2);
    chk("t6 pops", g_dut[0].pops, 1);
    repeat (3) @(negedge clk);
    chk("t6 ignored_start", g_dut[0].busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
